mult_div_sequencer: RTL and testbench
=====================================

// Module: mult_div_sequencer
// PURPOSE
//  Iterative multiply/divide unit beside the EX-stage ALU: runs MULT/MULTU/DIV/DIVU
//  over WIDTH radix-2 iterations, owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
//  Stalls the pipeline while an operation is in flight; flushable by later-stage exceptions.
// PARAMETERS
//  WIDTH  32  operand / HI / LO width in bits
// PORTS
//  clock__i     in   1      single clock; all state updates on rising edge
//  reset_n__i   in   1      reset, synchronous, active-low
//  Valid__i     in   1      EX instruction valid and of R-type MD class (decoded by main control)
//  Function__i  in   6      funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU,
//                           010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO
//  OperandA__i  in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//  OperandB__i  in   WIDTH  rt value (multiplier / divisor)
//  Flush__i     in   1      abort in-flight op, discard result
//  Result__o    out  WIDTH  combinational: HI if Function__i==MFHI, else LO
//  Hi__o        out  WIDTH  HI register
//  Lo__o        out  WIDTH  LO register
//  Busy__o      out  1      registered; 1 in RUN or FINISH
//  Done__o      out  1      registered; 1-cycle pulse in the cycle HI/LO take a new result
//  Stall__o     out  1      combinational: Valid__i & Busy__o
// BEHAVIOUR
//  Reset (reset_n__i==0 at edge): state=IDLE, HI=LO=0, Busy=Done=0, counter=0; overrides all.
//  States: IDLE -> RUN -> FINISH -> IDLE.
//  IDLE: Valid__i & MULT/DIV funct -> latch |A|,|B| (signed ops: two's-complement magnitude,
//    record sign_a, sign_b; unsigned: raw), op type, counter=WIDTH-1; go RUN.
//    Valid__i & MTHI/MTLO -> HI/LO <= OperandA__i next edge, stay IDLE, no Done.
//    MFHI/MFLO read Result__o same cycle; no state change. Other funct: ignored.
//  RUN: one iteration per cycle; counter decrements; counter==0 -> FINISH. Exactly WIDTH cycles.
//    Multiply: 2*WIDTH accumulator, shift-add on multiplier LSB.
//    Divide: restoring shift-subtract, one quotient bit per cycle.
//  FINISH: sign fix-up, write HI/LO, Done__o=1 next cycle, return IDLE.
//    Signed mult: product negated if sign_a^sign_b; HI=upper WIDTH, LO=lower WIDTH.
//    Signed div: quotient negated if sign_a^sign_b; remainder takes sign of dividend.
//    -2^(W-1) / -1: LO=0x80000000, HI=0 (natural wrap, no trap).
//    Divide by zero (divisor==0 at start): skip RUN, go FINISH directly; LO=all ones,
//    HI=OperandA__i as latched (raw). No exception raised.
//  Latency: start edge +WIDTH cycles RUN +1 FINISH; HI/LO valid and Done high at edge WIDTH+2
//    after acceptance. Busy__o high WIDTH+1 cycles (1 for div-by-zero).
//  Stall: any Valid__i while Busy__o holds the EX instruction; the op held is reissued and
//    accepted the cycle after return to IDLE (MFHI/MFLO then see the fresh result).
//  Flush__i in RUN/FINISH: return IDLE next edge, HI/LO unchanged, no Done. Flush in IDLE
//    suppresses the same-cycle start/MTHI/MTLO. Flush has priority over FINISH write.
//  Reset mid-operation: abandon op, reset values as above.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
//  MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU 100/0 -> Busy 1 cycle, LO=0xFFFFFFFF, HI=100; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  MFLO issued cycle 2 after DIVU 17/5 -> Stall high until IDLE, then Result__o=3 (HI=2).
//  MULT 5*5 then Flush__i at RUN cycle 10 -> Busy drops next edge, HI/LO keep prior values.
//  MTHI 0x1234 / MTLO 0xABCD in IDLE -> Hi__o/Lo__o update next edge; reset low mid-RUN -> all 0.

Source files
------------

// File: rtl/mult_div_sequencer.sv
// Iterative radix-2 multiply/divide unit that owns HI/LO, serves MFHI/MFLO/MTHI/MTLO
// and stalls the EX stage while an operation is in flight.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock__i,
    input  logic             reset_n__i,
    input  logic             Valid__i,
    input  logic [5:0]       Function__i,
    input  logic [WIDTH-1:0] OperandA__i,
    input  logic [WIDTH-1:0] OperandB__i,
    input  logic             Flush__i,
    output logic [WIDTH-1:0] Result__o,
    output logic [WIDTH-1:0] Hi__o,
    output logic [WIDTH-1:0] Lo__o,
    output logic             Busy__o,
    output logic             Done__o,
    output logic             Stall__o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div0_q,   div0_d;
    logic               done_q,   done_d;

    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    // Datapath: operand magnitudes, one shift-add / shift-subtract step, final sign fix-up.
    always_comb begin
        op_signed = ~Function__i[0];
        op_div    = Function__i[1];
        mag_a     = (op_signed && OperandA__i[WIDTH-1]) ? -OperandA__i : OperandA__i;
        mag_b     = (op_signed && OperandB__i[WIDTH-1]) ? -OperandB__i : OperandB__i;

        // Multiplier sits in the low half; the carry out of the add shifts back in on top.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder in the high half, dividend shifting out of the low half as quotient fills in.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        product   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quotient  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remainder = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case leaves a latch.
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Valid__i && !Flush__i) begin
                    case (Function__i)
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            a_d      = mag_a;
                            b_d      = mag_b;
                            sign_a_d = op_signed & OperandA__i[WIDTH-1];
                            sign_b_d = op_signed & OperandB__i[WIDTH-1];
                            is_div_d = op_div;
                            acc_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                            count_d  = CW'(WIDTH - 1);
                            if (op_div && OperandB__i == '0) begin
                                // Divide by zero reports the raw dividend in HI.
                                div0_d  = 1'b1;
                                a_d     = OperandA__i;
                                state_d = ST_FINISH;
                            end else begin
                                div0_d  = 1'b0;
                                state_d = ST_RUN;
                            end
                        end
                        FN_MTHI: hi_d = OperandA__i;
                        FN_MTLO: lo_d = OperandA__i;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (Flush__i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (!Flush__i) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end else begin
                        hi_d = product[2*WIDTH-1:WIDTH];
                        lo_d = product[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock__i) begin
        if (!reset_n__i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    assign Hi__o     = hi_q;
    assign Lo__o     = lo_q;
    assign Done__o   = done_q;
    assign Busy__o   = (state_q != ST_IDLE);
    assign Stall__o  = Valid__i & Busy__o;
    assign Result__o = (Function__i == FN_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomised and directed bench for mult_div_sequencer against an arithmetic reference model.
module tb_mult_div_sequencer;

    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [5:0]   funct;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    int checks = 0;
    int errors = 0;

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clock__i    (clk),
        .reset_n__i  (rst_n),
        .Valid__i    (valid),
        .Function__i (funct),
        .OperandA__i (op_a),
        .OperandB__i (op_b),
        .Flush__i    (flush),
        .Result__o   (result),
        .Hi__o       (hi),
        .Lo__o       (lo),
        .Busy__o     (busy),
        .Done__o     (done),
        .Stall__o    (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI, LO} straight from integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic signed [31:0] sq, sr;
        case (f)
            MULT: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                sp = sa * sb;
                return sp;
            end
            MULTU: return {32'h0, a} * {32'h0, b};
            DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Issue one MD op, wait for Done, check latency, busy length, HI/LO, Result and pulse width.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int cyc;
        int busy_cnt;
        int exp_lat;
        exp      = model(f, a, b);
        exp_lat  = ((f == DIV || f == DIVU) && b == 0) ? 1 : W + 1;
        valid    = 1'b1;
        funct    = f;
        op_a     = a;
        op_b     = b;
        tick();
        valid    = 1'b0;
        funct    = 6'b000000;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_busy"}, busy_cnt, exp_lat);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        funct = MFHI;
        #1;
        check({tag, "_mfhi"}, result, exp[63:32]);
        funct = MFLO;
        #1;
        check({tag, "_mflo"}, result, exp[31:0]);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [31:0] hold_hi, hold_lo;
        logic [5:0]  ops [4];
        int          stall_bad, cyc, done_seen;
        logic [31:0] ra, rb;

        ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;
        rst_n = 1'b0; valid = 1'b0; funct = '0; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // MTHI / MTLO
        valid = 1'b1; funct = MTHI; op_a = 32'h1234;
        tick();
        check("mthi", hi, 32'h1234);
        check("mthi_busy", busy, 0);
        funct = MTLO; op_a = 32'hABCD;
        tick();
        check("mtlo", lo, 32'hABCD);
        check("mthi_kept", hi, 32'h1234);
        valid = 1'b0;
        tick();

        // Flush in IDLE suppresses a move
        valid = 1'b1; funct = MTHI; op_a = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        valid = 1'b0; flush = 1'b0;
        check("idle_flush_mthi", hi, 32'h1234);

        // Directed corners
        run_op("multu_ff", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_ff_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_ff_lo_const", lo, 32'h0000_0001);
        run_op("mult_m3x7", MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_m3x7_lo_const", lo, 32'hFFFF_FFEB);
        run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_m7d2_lo_const", lo, 32'hFFFF_FFFD);
        run_op("divu_by0", DIVU, 32'd100, 32'd0);
        check("divu_by0_hi_const", hi, 32'd100);
        run_op("div_by0_neg", DIV, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE);

        // MFLO held behind a running DIVU
        valid = 1'b1; funct = DIVU; op_a = 32'd17; op_b = 32'd5;
        tick();
        funct = MFLO;
        stall_bad = 0; cyc = 0;
        while (!done && cyc < 100) begin
            if (!stall) stall_bad++;
            tick();
            cyc++;
        end
        check("stall_held", stall_bad, 0);
        check("stall_done", done, 1'b1);
        check("stall_stall_low", stall, 1'b0);
        check("stall_mflo", result, 32'd3);
        check("stall_hi", hi, 32'd2);
        valid = 1'b0;
        tick();

        // Flush in RUN
        hold_hi = hi; hold_lo = lo;
        valid = 1'b1; funct = MULT; op_a = 32'd5; op_b = 32'd5;
        tick();
        valid = 1'b0;
        repeat (10) tick();
        check("flush_run_busy_before", busy, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_run_busy", busy, 1'b0);
        done_seen = 0;
        repeat (40) begin
            if (done) done_seen++;
            tick();
        end
        check("flush_run_no_done", done_seen, 0);
        check("flush_run_hi", hi, hold_hi);
        check("flush_run_lo", lo, hold_lo);

        // Flush in FINISH beats the write
        valid = 1'b1; funct = MULTU; op_a = 32'd9; op_b = 32'd9;
        tick();
        valid = 1'b0;
        repeat (W) tick();
        check("flush_fin_busy_before", busy, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fin_done", done, 1'b0);
        check("flush_fin_busy", busy, 1'b0);
        check("flush_fin_hi", hi, hold_hi);
        check("flush_fin_lo", lo, hold_lo);

        // Randomised ops with biased corner operands
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(7))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(9);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ops[$urandom_range(3)], ra, rb);
        end

        // Reset mid-RUN
        valid = 1'b1; funct = MULT; op_a = 32'd123; op_b = 32'd456;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        run_op("post_rst", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
